// File: rtl/mem_pkg.sv
// Shared definitions for the load/store memory master: access-size encoding,
// controller states and the size-derived byte-lane and alignment masks.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  // Byte lanes covered by an access of the given size, low-aligned.
  function automatic logic [7:0] size_mask(size_e s);
    case (s)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(size_e s);
    case (s)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data aligner: moves the addressed lane of an 8-byte read word down to
// bit 0, truncates it to the access size and zero- or sign-extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [2:0]  i_offset,
  input  size_e       i_size,
  input  logic        i_signed,
  output logic [63:0] o_data
);

  logic [63:0] w_shift;

  // NOTE: every signal written in a combinational block gets a value on every
  // path (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    w_shift = i_data >> {i_offset, 3'b000};
    o_data  = w_shift;
    case (i_size)
      SZ_B:    o_data = {{56{i_signed & w_shift[7]}},  w_shift[7:0]};
      SZ_H:    o_data = {{48{i_signed & w_shift[15]}}, w_shift[15:0]};
      SZ_W:    o_data = {{32{i_signed & w_shift[31]}}, w_shift[31:0]};
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store master: accepts one request, performs at most
// one memory read or write cycle, then holds the response until taken.
module lsu_mem_master
  import mem_pkg::*;
#(
  parameter logic [63:0] RESET_ADDR = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        rd_en,
  output logic [63:0] rd_addr,
  input  logic [63:0] rd_data,
  output logic        we_en,
  output logic [63:0] we_addr,
  output logic [63:0] we_data,
  output logic [7:0]  we_mask
);

  state_e      r_state;
  logic [2:0]  r_offset;
  size_e       r_size;
  logic        r_signed;

  size_e       w_size;
  logic        w_misaligned;
  logic [7:0]  w_store_mask;
  logic [63:0] w_store_data;
  logic [63:0] w_load_data;

  assign w_size       = size_e'(req_size);
  assign w_misaligned = |(req_addr[2:0] & align_mask(w_size));
  assign w_store_mask = size_mask(w_size);

  always_comb begin
    for (int i = 0; i < 8; i++)
      w_store_data[i*8 +: 8] = w_store_mask[i] ? req_wdata[i*8 +: 8] : 8'h00;
  end

  // Gated by rst so no request is offered while reset is held.
  assign req_ready = rst & (r_state == ST_IDLE);

  mem_load_align u_align (
    .i_data   (rd_data),
    .i_offset (r_offset),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_load_data)
  );

  // NOTE: clocked state uses non-blocking (<=) assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_offset   <= 3'd0;
      r_size     <= SZ_B;
      r_signed   <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= RESET_ADDR;
      we_en      <= 1'b0;
      we_addr    <= RESET_ADDR;
      we_data    <= 64'd0;
      we_mask    <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_offset <= req_addr[2:0];
            r_size   <= w_size;
            r_signed <= req_signed;
            if (w_misaligned) begin
              r_state    <= ST_RSP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 64'd0;
            end else if (req_write) begin
              r_state <= ST_WR;
              we_en   <= 1'b1;
              we_addr <= req_addr;
              we_data <= w_store_data;
              we_mask <= w_store_mask;
            end else begin
              r_state <= ST_RD;
              rd_en   <= 1'b1;
              rd_addr <= {req_addr[63:3], 3'b000};
            end
          end
        end
        ST_RD: begin
          r_state    <= ST_RSP;
          rd_en      <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= w_load_data;
        end
        ST_WR: begin
          r_state    <= ST_RSP;
          we_en      <= 1'b0;
          we_data    <= 64'd0;
          we_mask    <= 8'd0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 64'd0;
        end
        ST_RSP: begin
          if (resp_ready) begin
            r_state    <= ST_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
